// File: rtl/exe_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 encodings,
// FSM state enumeration and the default datapath width.
package exe_muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// Combinational iteration block: UNROLL shift-add (multiply) or restoring
// subtract (divide) steps on unsigned magnitudes held in a {hi, lo} pair.
module muldiv_step
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int UNROLL = 1
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   t;
  logic [XLEN:0]   sum;

  // Multiply: hi accumulates, lo shifts the multiplier out and the product in.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    hi  = hi_i;
    lo  = lo_i;
    t   = '0;
    sum = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div_i) begin
        t = {hi, lo[XLEN-1]};
        if (t >= {1'b0, opd_i}) begin
          hi = t[XLEN-1:0] - opd_i;
          lo = {lo[XLEN-2:0], 1'b1};
        end else begin
          hi = t[XLEN-1:0];
          lo = {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        sum = {1'b0, hi} + (lo[0] ? {1'b0, opd_i} : {(XLEN+1){1'b0}});
        hi  = sum[XLEN:1];
        lo  = {sum[0], lo[XLEN-1:1]};
      end
    end
    hi_o = hi;
    lo_o = lo;
  end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative RISC-V M-extension unit: magnitude shift-add / restoring divide,
// sign fixup at the end, fast paths for divide-by-zero, overflow and reuse.
module exe_muldiv
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int UNROLL   = 1,
  parameter int REUSE_EN = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [1:0]      state_o
);

  localparam int N     = XLEN / UNROLL;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   raw1_q, raw1_d;
  logic [XLEN-1:0]   raw2_q, raw2_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              rv_q, rv_d;
  logic              r_signed_q, r_signed_d;
  logic [XLEN-1:0]   r_op1_q, r_op1_d;
  logic [XLEN-1:0]   r_op2_q, r_op2_d;
  logic [XLEN-1:0]   r_quo_q, r_quo_d;
  logic [XLEN-1:0]   r_rem_q, r_rem_d;

  logic [XLEN-1:0]   step_hi, step_lo;
  logic              is_div, s1, s2, neg1, neg2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div0, ovf, reuse_hit;
  logic [XLEN-1:0]   fast_quo, fast_rem;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  muldiv_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .is_div_i (op_q[2]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opd_i    (opd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Operand decode in IDLE; op_i[0] marks the unsigned divide forms.
  assign is_div    = op_i[2];
  assign s1        = is_div ? ~op_i[0] : (op_i == OP_MULH || op_i == OP_MULHSU);
  assign s2        = is_div ? ~op_i[0] : (op_i == OP_MULH);
  assign neg1      = s1 & op1_i[XLEN-1];
  assign neg2      = s2 & op2_i[XLEN-1];
  assign mag1      = neg1 ? -op1_i : op1_i;
  assign mag2      = neg2 ? -op2_i : op2_i;
  assign div0      = (op2_i == '0);
  assign ovf       = ~op_i[0] && (op1_i == MIN_INT) && (op2_i == '1);
  assign reuse_hit = (REUSE_EN != 0) && rv_q && (r_signed_q == ~op_i[0]) &&
                     (r_op1_q == op1_i) && (r_op2_q == op2_i);

  always_comb begin
    fast_quo = r_quo_q;
    fast_rem = r_rem_q;
    if (div0) begin
      fast_quo = '1;
      fast_rem = op1_i;
    end else if (ovf) begin
      fast_quo = MIN_INT;
      fast_rem = '0;
    end
  end

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = neg_rem_q ? -hi_q : hi_q;

  // Handshake: start_i is accepted only in IDLE without flush_i; done_o is a
  // one-cycle pulse in DONE with result_o valid, and result_o then holds.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    opd_d      = opd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    raw1_d     = raw1_q;
    raw2_d     = raw2_q;
    result_d   = result_q;
    rv_d       = rv_q;
    r_signed_d = r_signed_q;
    r_op1_d    = r_op1_q;
    r_op2_d    = r_op2_q;
    r_quo_d    = r_quo_q;
    r_rem_d    = r_rem_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_d   = op_i;
            raw1_d = op1_i;
            raw2_d = op2_i;
            if (is_div && (div0 || ovf || reuse_hit)) begin
              result_d = op_i[1] ? fast_rem : fast_quo;
              state_d  = ST_DONE;
            end else begin
              cnt_d     = '0;
              opd_d     = is_div ? mag2 : mag1;
              hi_d      = '0;
              lo_d      = is_div ? mag1 : mag2;
              neg_d     = neg1 ^ neg2;
              neg_rem_d = neg1;
              state_d   = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = ST_FIXUP;
        end
        ST_FIXUP: begin
          if (op_q[2]) begin
            result_d   = op_q[1] ? rem_fix : quo_fix;
            rv_d       = 1'b1;
            r_signed_d = ~op_q[0];
            r_op1_d    = raw1_q;
            r_op2_d    = raw2_q;
            r_quo_d    = quo_fix;
            r_rem_d    = rem_fix;
          end else begin
            result_d = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          end
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      opd_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      raw1_q     <= '0;
      raw2_q     <= '0;
      result_q   <= '0;
      rv_q       <= 1'b0;
      r_signed_q <= 1'b0;
      r_op1_q    <= '0;
      r_op2_q    <= '0;
      r_quo_q    <= '0;
      r_rem_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      opd_q      <= opd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      raw1_q     <= raw1_d;
      raw2_q     <= raw2_d;
      result_q   <= result_d;
      rv_q       <= rv_d;
      r_signed_q <= r_signed_d;
      r_op1_q    <= r_op1_d;
      r_op2_q    <= r_op2_d;
      r_quo_q    <= r_quo_d;
      r_rem_q    <= r_rem_d;
    end
  end

  assign stall_o  = ~rst_i & (((state_q == ST_IDLE) & start_i & ~flush_i) |
                              (state_q == ST_CALC) | (state_q == ST_FIXUP));
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;
  assign state_o  = state_q;

endmodule
